// File: rtl/led_counter.sv
// rtl/led_counter.sv - 8-bit LED counter with prescaled tick, debounced run/pause button, up/down dir.
// Define LED_PWM_EN to dim the LEDs with an 8-bit PWM of duty PWM_DUTY/256.
module led_counter #(
  parameter int TICK_DIV        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int PWM_DUTY        = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       dir,
  output logic [7:0] led,
  output logic [7:0] count,
  output logic       wrap,
  output logic       paused
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (PWM_DUTY < 0 || PWM_DUTY > 256) begin : g_bad_duty
    $error("PWM_DUTY must be within 0..256");
  end

  typedef enum logic {RUN, PAUSED} state_t;

  state_t        state;
  logic          btn_m, btn_s;
  logic          deb, deb_q, press;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] presc;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // A single cycle where btn_s agrees with deb restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s != deb) begin
      if (deb_cnt == DEB_MAX) begin
        deb     <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0;
      press <= 1'b0;
    end else begin
      deb_q <= deb;
      press <= deb & ~deb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      paused <= 1'b0;
    end else if (press) begin
      state  <= (state == RUN) ? PAUSED : RUN;
      paused <= (state == RUN);
    end
  end

  assign tick = (state == RUN) && (presc == PRE_MAX);

  // The prescaler holds while paused so a resume completes the interrupted period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'h00;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        if (dir) begin
          count <= count - 8'd1;
          wrap  <= (count == 8'h00);
        end else begin
          count <= count + 8'd1;
          wrap  <= (count == 8'hFF);
        end
      end
    end
  end

`ifdef LED_PWM_EN
  localparam logic [8:0] DUTY = 9'(PWM_DUTY);

  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= 8'h00;
      led     <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      led     <= count & {8{({1'b0, pwm_cnt} < DUTY)}};
    end
  end
`else
  assign led = count;
`endif

endmodule

// File: tb/tb_led_counter.sv
// tb/tb_led_counter.sv - directed table-driven bench for led_counter (TICK_DIV=4, DEBOUNCE_CYCLES=8).
module tb_led_counter;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       dir;
  logic [7:0] led;
  logic [7:0] count;
  logic       wrap;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;

  led_counter #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(8),
    .PWM_DUTY       (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .dir   (dir),
    .led   (led),
    .count (count),
    .wrap  (wrap),
    .paused(paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    int         cycles;
    logic [7:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Each step lands 1 time unit after a rising edge; inputs are driven and outputs sampled there.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic d);
    rst = 1'b1;
    btn = 1'b0;
    dir = d;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int wraps, wrap_at, led_bad, pause_bad, on_cnt, off_cnt, other_cnt;
    logic [7:0] held;

    rst = 1'b1;
    btn = 1'b0;
    dir = 1'b0;

    vecs[0]  = '{1'b0, 0,    8'd0,   1'b0};
    vecs[1]  = '{1'b0, 3,    8'd0,   1'b0};
    vecs[2]  = '{1'b0, 4,    8'd1,   1'b0};
    vecs[3]  = '{1'b0, 8,    8'd2,   1'b0};
    vecs[4]  = '{1'b0, 400,  8'd100, 1'b0};
    vecs[5]  = '{1'b0, 1020, 8'd255, 1'b0};
    vecs[6]  = '{1'b0, 1024, 8'd0,   1'b1};
    vecs[7]  = '{1'b0, 1025, 8'd0,   1'b0};
    vecs[8]  = '{1'b1, 4,    8'd255, 1'b1};
    vecs[9]  = '{1'b1, 5,    8'd255, 1'b0};
    vecs[10] = '{1'b1, 8,    8'd254, 1'b0};
    vecs[11] = '{1'b1, 40,   8'd246, 1'b0};

    for (int i = 0; i < 12; i++) begin
      do_reset(vecs[i].dir);
      cyc(vecs[i].cycles);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
      check($sformatf("vec%0d_paused", i), paused, 0);
`ifndef LED_PWM_EN
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_count);
`endif
    end

    // Full up-count lap: one wrap, exactly on the 255->0 step.
    do_reset(1'b0);
    wraps = 0; wrap_at = 0; led_bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      cyc(1);
      if (wrap) begin
        wraps++;
        wrap_at = i;
      end
      if (led !== count) led_bad++;
    end
    check("lap_wrap_count", wraps, 1);
    check("lap_wrap_cycle", wrap_at, 1024);
    check("lap_count", count, 0);
`ifndef LED_PWM_EN
    check("lap_led_eq_count", led_bad, 0);
`endif

    // Bouncy button then held: one press, 11 cycles after the last edge.
    do_reset(1'b0);
    pause_bad = 0;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        if (paused !== 1'b0) pause_bad++;
      end
    end
    btn = 1'b1;
    for (int j = 0; j < 11; j++) begin
      cyc(1);
      if (paused !== 1'b0) pause_bad++;
    end
    check("bounce_no_early_pause", pause_bad, 0);
    cyc(1);
    check("bounce_paused", paused, 1);
    check("bounce_count_at_pause", count, 10);
    pause_bad = 0;
    for (int j = 0; j < 100; j++) begin
      cyc(1);
      if (paused !== 1'b1 || count !== 8'd10) pause_bad++;
    end
    check("pause_frozen_100", pause_bad, 0);
    btn = 1'b0;
    cyc(20);
    check("release_no_toggle", paused, 1);
    btn = 1'b1;
    cyc(11);
    check("resume_not_yet", paused, 1);
    cyc(1);
    check("resume_paused", paused, 0);
    check("resume_count_hold", count, 10);
    cyc(1);
    check("resume_presc_remaining", count, 10);
    cyc(1);
    check("resume_first_tick", count, 11);

    // Short glitch is rejected.
    do_reset(1'b0);
    cyc(10);
    btn = 1'b1;
    pause_bad = 0;
    for (int j = 0; j < 5; j++) begin
      cyc(1);
      if (paused !== 1'b0) pause_bad++;
    end
    btn = 1'b0;
    for (int j = 0; j < 30; j++) begin
      cyc(1);
      if (paused !== 1'b0) pause_bad++;
    end
    check("glitch_no_pause", pause_bad, 0);
    check("glitch_count", count, 11);

    // Async reset while paused at 0x5A.
    do_reset(1'b0);
    cyc(350);
    btn = 1'b1;
    cyc(12);
    check("pre_rst_paused", paused, 1);
    check("pre_rst_count", count, 8'h5A);
    cyc(5);
    rst = 1'b1;
    #2;
    check("async_rst_count", count, 0);
    check("async_rst_led", led, 0);
    check("async_rst_wrap", wrap, 0);
    check("async_rst_paused", paused, 0);
    btn = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check("post_rst_count", count, 1);
    check("post_rst_paused", paused, 0);

    // Park the count at 0xFF and observe the LEDs for 256 cycles.
    do_reset(1'b0);
    cyc(1009);
    btn = 1'b1;
    cyc(12);
    check("park_paused", paused, 1);
    held = count;
    check("park_count", held, 8'hFF);
    on_cnt = 0; off_cnt = 0; other_cnt = 0;
    for (int j = 0; j < 256; j++) begin
      cyc(1);
      if (led === 8'hFF) on_cnt++;
      else if (led === 8'h00) off_cnt++;
      else other_cnt++;
    end
`ifdef LED_PWM_EN
    check("pwm_on_cycles", on_cnt, 64);
    check("pwm_off_cycles", off_cnt, 192);
`else
    check("led_on_cycles", on_cnt, 256);
`endif
    check("led_other_values", other_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
